// File: rtl/dma_copy_engine.sv
// dma_copy_engine: single-channel word-copy DMA master on a req/gnt/rvalid port.
// Ports: clk_sys/rst (async low), cfg_src/dst/len + start/abort,
//   status busy/done/err/words_done/last_word, mem_* bus master signals.
module dma_copy_engine #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [LEN_W-1:0]  words_done,
   output logic [DATA_W-1:0] last_word,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN
   } state_t;

   state_t state, state_nx;

   logic [ADDR_W-1:0] src, src_nx;
   logic [ADDR_W-1:0] dst, dst_nx;
   logic [LEN_W-1:0]  len, len_nx;
   logic [DATA_W-1:0] buffer, buffer_nx;
   logic [LEN_W-1:0]  words_nx, words_inc;
   logic [DATA_W-1:0] last_nx, wdata_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic              err_nx, busy_nx, done_nx, req_nx, we_nx;

   assign words_inc = words_done + LEN_W'(1);

   always_ff @(posedge clk_sys or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (start) state_nx = (cfg_len == '0) ? FIN : RD_REQ;
         RD_REQ:
            // a granted read is in flight and must finish before abort
            if (mem_gnt)    state_nx = RD_WAIT;
            else if (abort) state_nx = FIN;
         RD_WAIT:
            if (mem_rvalid) state_nx = mem_err ? FIN : WR_REQ;
         WR_REQ:
            if (mem_gnt) state_nx = WR_WAIT;
         WR_WAIT:
            if (mem_rvalid) begin
               if (mem_err)                         state_nx = FIN;
               else if (words_inc == len || abort)  state_nx = FIN;
               else                                 state_nx = RD_REQ;
            end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of datapath and outputs; outputs are derived from the
   // next state so that every output comes straight from a flop.
   always_comb begin
      src_nx    = src;
      dst_nx    = dst;
      len_nx    = len;
      buffer_nx = buffer;
      err_nx    = err;
      words_nx  = words_done;
      last_nx   = last_word;
      unique case (state)
         IDLE:
            if (start) begin
               src_nx   = cfg_src;
               dst_nx   = cfg_dst;
               len_nx   = cfg_len;
               err_nx   = 1'b0;
               words_nx = '0;
            end
         RD_WAIT:
            if (mem_rvalid) begin
               if (mem_err) err_nx    = 1'b1;
               else         buffer_nx = mem_rdata;
            end
         WR_WAIT:
            if (mem_rvalid) begin
               if (mem_err) begin
                  err_nx = 1'b1;
               end else begin
                  words_nx = words_inc;
                  last_nx  = buffer;
                  src_nx   = src + ADDR_W'(4);
                  dst_nx   = dst + ADDR_W'(4);
               end
            end
         default: ;
      endcase
      busy_nx  = (state_nx != IDLE);
      done_nx  = (state_nx == FIN);
      req_nx   = (state_nx == RD_REQ) || (state_nx == WR_REQ);
      we_nx    = (state_nx == WR_REQ);
      addr_nx  = mem_addr;
      wdata_nx = mem_wdata;
      if (state_nx == RD_REQ) addr_nx = src_nx;
      if (state_nx == WR_REQ) begin
         addr_nx  = dst_nx;
         wdata_nx = buffer_nx;
      end
   end

   always_ff @(posedge clk_sys or negedge rst) begin
      if (!rst) begin
         src        <= '0;
         dst        <= '0;
         len        <= '0;
         buffer     <= '0;
         err        <= 1'b0;
         words_done <= '0;
         last_word  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         src        <= src_nx;
         dst        <= dst_nx;
         len        <= len_nx;
         buffer     <= buffer_nx;
         err        <= err_nx;
         words_done <= words_nx;
         last_word  <= last_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         mem_req    <= req_nx;
         mem_we     <= we_nx;
         mem_addr   <= addr_nx;
         mem_wdata  <= wdata_nx;
      end
   end

endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
Single-channel memory-to-memory DMA master that copies a block of 32-bit words from a source to a destination address over the SoC's simple req/gnt/rvalid memory port. It sits directly upstream of the SoC result-capture path. It is the engine that produces the words later presented on the top-level data_out observation bus. Software or a bench configures src/dst/len, pulses start, and watches busy/done/err.

Parameters:
ADDR_W, 32, byte-address width of mem_addr, cfg_src and cfg_dst.
DATA_W, 32, word width. Fixed at 32 because the address stride is 4 bytes.
LEN_W, 16, width of cfg_len and words_done.

Ports:
clk_sys  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset.
cfg_src  in  ADDR_W  source byte address, sampled on accepted start.
cfg_dst  in  ADDR_W  destination byte address, sampled on accepted start.
cfg_len  in  LEN_W  number of words to copy, sampled on accepted start.
start  in  1  begin a transfer. Accepted only in IDLE.
abort  in  1  request early stop. Level-sampled.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of a transfer (normal, zero-length, aborted or errored).
err  out  1  sticky. Set by mem_err, cleared by the next accepted start.
words_done  out  LEN_W  number of words fully written in the current or last transfer.
last_word  out  DATA_W  last word written to the destination.
mem_req  out  1  bus request.
mem_we  out  1  1 = write, 0 = read. Valid while mem_req is high.
mem_addr  out  ADDR_W  byte address.
mem_wdata  out  DATA_W  write data.
mem_gnt  in  1  request accepted this cycle.
mem_rvalid  in  1  response for the granted access (read data or write acknowledge).
mem_rdata  in  DATA_W  read data, valid with mem_rvalid.
mem_err  in  1  error response, valid with mem_rvalid.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, internal address/length/buffer registers 0. Reset mid-transfer drops mem_req immediately; no done pulse.
- All outputs are registered.
- Bus rules:
  - One outstanding access at most.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_gnt is high. mem_req is low the cycle after gnt.
  - mem_rvalid is sampled only in RD_WAIT/WR_WAIT and arrives at least 1 cycle after gnt.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - start=1 latches src, dst and len; clears err and words_done.
  - len=0 goes to FIN, with no bus activity.
  - Otherwise goes to RD_REQ.
  - start while busy is ignored.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=src. On gnt, go to RD_WAIT.
- RD_WAIT: on rvalid:
  - mem_err=1: set err, go to FIN.
  - Otherwise capture mem_rdata into the buffer, go to WR_REQ.
- WR_REQ: mem_req=1, mem_we=1, mem_addr=dst, mem_wdata=buffer. On gnt, go to WR_WAIT.
- WR_WAIT: on rvalid:
  - mem_err=1: set err, go to FIN. words_done is not incremented.
  - Otherwise:
    - words_done+1, last_word=buffer, src+=4, dst+=4. Addresses wrap modulo 2^ADDR_W.
    - words_done==len, or abort high this cycle: go to FIN.
    - Else go to RD_REQ.
- abort:
  - Honoured only at a word boundary (WR_WAIT completion), or in RD_REQ before gnt.
  - In RD_REQ before gnt: drop req, go to FIN.
  - An in-flight read/write always completes.
- FIN: done=1 for exactly one cycle, busy=1, then IDLE (busy=0).
- start sampled in the same cycle as FIN is ignored.
- Throughput with gnt immediate and rvalid one cycle later: 4 cycles/word.
- Latency: done is high N*4+1 cycles after the start-sampling edge for N≥1, and 1 cycle after for N=0.

Test Plan:
1. Zero-wait copy, src=0x100, dst=0x200, len=3, memory holding 0xA0,0xA1,0xA2:
   - Destination holds 0xA0..0xA2.
   - Addresses issued in order: 0x100, 0x200, 0x104, 0x204, 0x108, 0x208.
   - done pulses 13 cycles after start; words_done=3; last_word=0xA2; err=0.
2. len=0:
   - done one cycle after start, mem_req never asserted, busy high for exactly 1 cycle.
3. Grant stall of 3 cycles on every request:
   - req/addr/wdata held stable during each stall.
   - Copy completes correctly; 10 cycles/word.
4. mem_err with rvalid on the 2nd read of len=4:
   - err=1, words_done=1, done pulse, no further requests.
   - Next start clears err.
5. abort asserted during the 2nd write's WR_WAIT, len=5:
   - 2nd write completes, words_done=2, done pulse, no 3rd read.
   - start pulsed while busy is ignored.
6. Wrap and reset:
   - src=0xFFFFFFFC, len=2: second read at 0x00000000.
   - rst low mid-RD_WAIT: all outputs 0 immediately, no done.
